bpred_update_queue: RTL

// Execute-side companion of the bimodal/BTB predictor. Captures per-fetch prediction metadata in order,

---
 rtl/bpred_pkg.sv | 28 ++
 rtl/bpred_meta_fifo.sv | 50 +++++
 rtl/bpred_update_queue.sv | 107 ++++++++++
 3 files changed

// File: rtl/bpred_pkg.sv
// Shared layout and constants for the branch-predictor update queue.
// One queue entry holds the fetch-time prediction metadata needed at execute.
package bpred_pkg;

    localparam int DEPTH     = 8;
    localparam int PTR_W     = 3;
    localparam int PC_W      = 32;
    localparam int BIMODAL_W = 12;
    localparam int CARRY_W   = 9;
    localparam int ENTRY_W   = PC_W + PC_W + BIMODAL_W + CARRY_W + 1;

    localparam logic [3:0] BE_BIMODAL = 4'b0001;
    localparam logic [3:0] BE_FULL    = 4'b1111;

    typedef struct packed {
        logic [PC_W-1:0]      pc4;
        logic [PC_W-1:0]      p_target;
        logic [BIMODAL_W-1:0] bimodal;
        logic [CARRY_W-1:0]   bit_carry;
        logic                 p_dir;
    } bpred_entry_t;

    // Bimodal metadata is {index[9:0], counter[1:0]}.
    function automatic logic [9:0] bimodal_index(input logic [BIMODAL_W-1:0] b);
        return b[BIMODAL_W-1:2];
    endfunction

endpackage

// File: rtl/bpred_meta_fifo.sv
// Synchronous FIFO for in-flight prediction metadata, with a one-cycle flush.
// Flush discards all entries by snapping the read pointer to the write pointer.
module bpred_meta_fifo #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int W     = 86
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [W-1:0]     rdata,
    output logic [PTR_W:0]   count,
    output logic             empty
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, do_push, do_pop;

    assign full    = (count == DEPTH[PTR_W:0]);
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/bpred_update_queue.sv
// Execute-side predictor update queue: resolves stored predictions against the
// actual outcome, registers the predictor write packet and redirects on a miss.
module bpred_update_queue
    import bpred_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_PC4,
    input  logic                 fetch_p_dir,
    input  logic [31:0]          fetch_p_target,
    input  logic [BIMODAL_W-1:0] fetch_bimodal,
    input  logic [CARRY_W-1:0]   fetch_bit_carry,
    output logic                 queue_full,
    input  logic                 execute_valid,
    input  logic                 execute_is_branch,
    input  logic                 execute_dir,
    input  logic [31:0]          execute_target,
    input  logic                 soin_bpredictor_stall,
    output logic                 execute_bpredictor_update,
    output logic [31:0]          execute_bpredictor_PC4,
    output logic [31:0]          execute_bpredictor_target,
    output logic                 execute_bpredictor_dir,
    output logic                 execute_bpredictor_miss,
    output logic [BIMODAL_W-1:0] execute_bpredictor_bimodal,
    output logic [29:0]          up_btb_data,
    output logic [CARRY_W-1:0]   up_carry_data,
    output logic [3:0]           byte_en,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_PC,
    output logic                 queue_err
);
    bpred_entry_t   wr_entry, rd_entry;
    logic [PTR_W:0] count;
    logic           empty, deq_req, deq_fire, enq_fire, flush;
    logic           dir_eff, tgt_mismatch, miss, btb_write;

    assign wr_entry = '{pc4: fetch_PC4, p_target: fetch_p_target, bimodal: fetch_bimodal,
                        bit_carry: fetch_bit_carry, p_dir: fetch_p_dir};

    assign queue_full = (count == DEPTH[PTR_W:0]);
    assign deq_req    = execute_valid & ~soin_bpredictor_stall;
    assign deq_fire   = deq_req & ~empty;

    // A non-branch never actually redirects, so a predicted-taken one is a miss.
    assign dir_eff      = execute_is_branch & execute_dir;
    assign tgt_mismatch = (rd_entry.p_target != execute_target);
    assign miss         = (rd_entry.p_dir != dir_eff) | (rd_entry.p_dir & dir_eff & tgt_mismatch);
    assign btb_write    = dir_eff & (~rd_entry.p_dir | tgt_mismatch);
    assign flush        = deq_fire & miss;
    assign enq_fire     = fetch_valid & ~queue_full & ~flush;

    bpred_meta_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(ENTRY_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (enq_fire),
        .wdata (wr_entry),
        .pop   (deq_fire),
        .flush (flush),
        .rdata (rd_entry),
        .count (count),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            execute_bpredictor_update  <= 1'b0;
            execute_bpredictor_PC4     <= '0;
            execute_bpredictor_target  <= '0;
            execute_bpredictor_dir     <= 1'b0;
            execute_bpredictor_miss    <= 1'b0;
            execute_bpredictor_bimodal <= '0;
            up_btb_data                <= '0;
            up_carry_data              <= '0;
            byte_en                    <= '0;
            redirect_valid             <= 1'b0;
            redirect_PC                <= '0;
            queue_err                  <= 1'b0;
        end else begin
            redirect_valid <= flush;
            redirect_PC    <= flush ? (dir_eff ? execute_target : rd_entry.pc4) : '0;
            if (deq_req & empty) queue_err <= 1'b1;
            if (deq_fire) begin
                execute_bpredictor_update  <= execute_is_branch;
                execute_bpredictor_PC4     <= rd_entry.pc4;
                execute_bpredictor_target  <= execute_target;
                execute_bpredictor_dir     <= dir_eff;
                execute_bpredictor_miss    <= miss;
                execute_bpredictor_bimodal <= rd_entry.bimodal;
                up_btb_data                <= btb_write ? execute_target[31:2] : '0;
                up_carry_data              <= rd_entry.bit_carry;
                byte_en                    <= btb_write ? BE_FULL : BE_BIMODAL;
            end else if (!soin_bpredictor_stall) begin
                // Packet is a one-cycle event; a stalled predictor keeps it visible.
                execute_bpredictor_update  <= 1'b0;
                execute_bpredictor_PC4     <= '0;
                execute_bpredictor_target  <= '0;
                execute_bpredictor_dir     <= 1'b0;
                execute_bpredictor_miss    <= 1'b0;
                execute_bpredictor_bimodal <= '0;
                up_btb_data                <= '0;
                up_carry_data              <= '0;
                byte_en                    <= '0;
            end
        end
    end
endmodule
